// File: rtl/memory_register_bank_if.sv
// Request/response bundle for memory_register_bank: write, delete and read strobes plus occupancy status.
// The master drives requests; the slave (the bank) returns read responses and occupancy.
interface memory_register_bank_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
);
    localparam int IDX_W = $clog2(DEPTH);

    logic             wr_en;
    logic [IDX_W-1:0] wr_idx;
    logic [WIDTH-1:0] wr_data;
    logic             del_en;
    logic [IDX_W-1:0] del_idx;
    logic             rd_en;
    logic [IDX_W-1:0] rd_idx;
    logic             rd_valid;
    logic             rd_hit;
    logic [WIDTH-1:0] rd_data;
    logic             parity_err;
    logic [IDX_W-1:0] free_idx;
    logic [IDX_W:0]   count;
    logic             full;
    logic             empty;

    modport master (
        output wr_en, wr_idx, wr_data, del_en, del_idx, rd_en, rd_idx,
        input  rd_valid, rd_hit, rd_data, parity_err, free_idx, count, full, empty
    );

    modport slave (
        input  wr_en, wr_idx, wr_data, del_en, del_idx, rd_en, rd_idx,
        output rd_valid, rd_hit, rd_data, parity_err, free_idx, count, full, empty
    );
endinterface

// File: rtl/memory_register_bank.sv
// Valid-tagged register bank with write/delete/read ports and occupancy tracking; optional even parity via MEMORY_REGISTER_BANK_PARITY_EN.
// Reads answer one cycle after rd_en; no backpressure, every request is accepted or ignored the same cycle.
module memory_register_bank #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    memory_register_bank_if.slave  bus
);
    localparam int IDX_W = $clog2(DEPTH);

    logic [DEPTH-1:0] valid_q, valid_d;
    logic [WIDTH-1:0] data_q [DEPTH];
    logic [WIDTH-1:0] data_d [DEPTH];
    logic [IDX_W:0]   count_q, count_d;
    logic             rd_valid_q, rd_valid_d;
    logic             rd_hit_q, rd_hit_d;
    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic [IDX_W-1:0] free_idx;

`ifdef MEMORY_REGISTER_BANK_PARITY_EN
    logic [DEPTH-1:0] par_q, par_d;
    logic             parity_err_q, parity_err_d;
`endif

    // Out-of-range indices never match a loop index, so they fall through with no effect.
    always_comb begin
        valid_d    = valid_q;
        data_d     = data_q;
        count_d    = '0;
        rd_valid_d = bus.rd_en;
        rd_hit_d   = rd_hit_q;
        rd_data_d  = rd_data_q;
`ifdef MEMORY_REGISTER_BANK_PARITY_EN
        par_d        = par_q;
        parity_err_d = parity_err_q;
`endif
        if (bus.rd_en) begin
            rd_hit_d  = 1'b0;
            rd_data_d = '0;
`ifdef MEMORY_REGISTER_BANK_PARITY_EN
            parity_err_d = 1'b0;
`endif
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (bus.rd_en && bus.rd_idx == IDX_W'(i) && valid_q[i]) begin
                rd_hit_d  = 1'b1;
                rd_data_d = data_q[i];
`ifdef MEMORY_REGISTER_BANK_PARITY_EN
                parity_err_d = (^data_q[i]) != par_q[i];
`endif
            end
            if (bus.del_en && bus.del_idx == IDX_W'(i)) begin
                valid_d[i] = 1'b0;
                data_d[i]  = '0;
`ifdef MEMORY_REGISTER_BANK_PARITY_EN
                par_d[i] = 1'b0;
`endif
            end
            // Write is applied after delete so a same-index collision leaves the entry written.
            if (bus.wr_en && bus.wr_idx == IDX_W'(i)) begin
                valid_d[i] = 1'b1;
                data_d[i]  = bus.wr_data;
`ifdef MEMORY_REGISTER_BANK_PARITY_EN
                par_d[i] = ^bus.wr_data;
`endif
            end
            count_d = count_d + {{IDX_W{1'b0}}, valid_d[i]};
        end
    end

    always_comb begin
        free_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                free_idx = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q    <= '0;
            data_q     <= '{default: '0};
            count_q    <= '0;
            rd_valid_q <= 1'b0;
            rd_hit_q   <= 1'b0;
            rd_data_q  <= '0;
`ifdef MEMORY_REGISTER_BANK_PARITY_EN
            par_q        <= '0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            valid_q    <= valid_d;
            data_q     <= data_d;
            count_q    <= count_d;
            rd_valid_q <= rd_valid_d;
            rd_hit_q   <= rd_hit_d;
            rd_data_q  <= rd_data_d;
`ifdef MEMORY_REGISTER_BANK_PARITY_EN
            par_q        <= par_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_hit   = rd_hit_q;
    assign bus.rd_data  = rd_data_q;
    assign bus.count    = count_q;
    assign bus.free_idx = free_idx;
    assign bus.full     = count_q == (IDX_W+1)'(DEPTH);
    assign bus.empty    = count_q == '0;
`ifdef MEMORY_REGISTER_BANK_PARITY_EN
    assign bus.parity_err = parity_err_q;
`else
    assign bus.parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_memory_register_bank.sv
// Directed bench for memory_register_bank: an 8-entry and a 6-entry instance, checked with immediate assertions.
module tb_memory_register_bank;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    memory_register_bank_if #(.WIDTH(32), .DEPTH(8)) bus  ();
    memory_register_bank_if #(.WIDTH(32), .DEPTH(6)) bus6 ();

    memory_register_bank #(.WIDTH(32), .DEPTH(8)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
    memory_register_bank #(.WIDTH(32), .DEPTH(6)) dut6 (.clk(clk), .rst_n(rst_n), .bus(bus6.slave));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.wr_en = 0;  bus.del_en = 0;  bus.rd_en = 0;
        bus6.wr_en = 0; bus6.del_en = 0; bus6.rd_en = 0;
    endtask

    initial begin
        bus.wr_idx = 0;  bus.wr_data = 0;  bus.del_idx = 0;  bus.rd_idx = 0;
        bus6.wr_idx = 0; bus6.wr_data = 0; bus6.del_idx = 0; bus6.rd_idx = 0;
        idle();
        bus.wr_en = 1; bus.wr_idx = 3; bus.wr_data = 32'hDEAD; bus.rd_en = 1;
        tick(); tick();
        chk("rst_rd_valid", bus.rd_valid, 0);
        chk("rst_rd_hit", bus.rd_hit, 0);
        chk("rst_rd_data", bus.rd_data, 0);
        chk("rst_parity", bus.parity_err, 0);
        chk("rst_count", bus.count, 0);
        chk("rst_empty", bus.empty, 1);
        chk("rst_full", bus.full, 0);
        chk("rst_free", bus.free_idx, 0);
        idle();
        rst_n = 1;

        for (int i = 0; i < 8; i++) begin
            bus.wr_en = 1; bus.wr_idx = 3'(i); bus.wr_data = 32'h11 * (i + 1);
            tick();
            if (i == 0) begin
                chk("first_count", bus.count, 1);
                chk("first_free", bus.free_idx, 1);
                chk("first_empty", bus.empty, 0);
            end
        end
        idle();
        chk("fill_count", bus.count, 8);
        chk("fill_full", bus.full, 1);
        chk("fill_free", bus.free_idx, 0);

        bus.rd_en = 1; bus.rd_idx = 3;
        tick();
        idle();
        chk("rd3_valid", bus.rd_valid, 1);
        chk("rd3_hit", bus.rd_hit, 1);
        chk("rd3_data", bus.rd_data, 32'h44);
        chk("rd3_parity", bus.parity_err, 0);
        tick();
        chk("hold_valid", bus.rd_valid, 0);
        chk("hold_hit", bus.rd_hit, 1);
        chk("hold_data", bus.rd_data, 32'h44);

        bus.del_en = 1; bus.del_idx = 2;
        tick();
        idle();
        chk("del2_count", bus.count, 7);
        chk("del2_full", bus.full, 0);
        chk("del2_free", bus.free_idx, 2);
        bus.rd_en = 1; bus.rd_idx = 2;
        tick();
        idle();
        chk("rd2_valid", bus.rd_valid, 1);
        chk("rd2_hit", bus.rd_hit, 0);
        chk("rd2_data", bus.rd_data, 0);

        bus.wr_en = 1; bus.wr_idx = 5; bus.wr_data = 32'hAB;
        bus.del_en = 1; bus.del_idx = 5;
        bus.rd_en = 1; bus.rd_idx = 5;
        tick();
        idle();
        chk("coll_rd_data", bus.rd_data, 32'h66);
        chk("coll_rd_hit", bus.rd_hit, 1);
        chk("coll_count", bus.count, 7);
        bus.rd_en = 1; bus.rd_idx = 5;
        tick();
        idle();
        chk("coll_new_data", bus.rd_data, 32'hAB);
        chk("coll_new_hit", bus.rd_hit, 1);
        chk("coll_new_count", bus.count, 7);

        bus.wr_en = 1; bus.wr_idx = 2; bus.wr_data = 32'h5A;
        bus.del_en = 1; bus.del_idx = 0;
        tick();
        idle();
        chk("split_count", bus.count, 7);
        chk("split_free", bus.free_idx, 0);
        bus.rd_en = 1; bus.rd_idx = 2;
        tick();
        bus.rd_idx = 0;
        chk("split_rd2", bus.rd_data, 32'h5A);
        tick();
        idle();
        chk("split_rd0_hit", bus.rd_hit, 0);
        chk("split_rd0_data", bus.rd_data, 0);

        bus.wr_en = 1; bus.wr_idx = 7; bus.wr_data = 32'h99;
        tick();
        idle();
        chk("overwrite_count", bus.count, 7);

        bus6.wr_en = 1; bus6.wr_idx = 7; bus6.wr_data = 32'hFF;
        tick();
        bus6.wr_idx = 6;
        chk("d6_oor_count", bus6.count, 0);
        chk("d6_oor_empty", bus6.empty, 1);
        tick();
        bus6.wr_en = 0;
        chk("d6_oor6_count", bus6.count, 0);
        bus6.rd_en = 1; bus6.rd_idx = 7;
        tick();
        bus6.rd_en = 0;
        chk("d6_rd7_valid", bus6.rd_valid, 1);
        chk("d6_rd7_hit", bus6.rd_hit, 0);
        chk("d6_rd7_data", bus6.rd_data, 0);
        for (int i = 0; i < 6; i++) begin
            bus6.wr_en = 1; bus6.wr_idx = 3'(i); bus6.wr_data = 32'(i + 1);
            tick();
        end
        bus6.wr_en = 0;
        chk("d6_full", bus6.full, 1);
        chk("d6_full_count", bus6.count, 6);
        chk("d6_full_free", bus6.free_idx, 0);
        bus6.del_en = 1; bus6.del_idx = 7;
        tick();
        bus6.del_idx = 4;
        chk("d6_del7_count", bus6.count, 6);
        tick();
        bus6.del_en = 0;
        chk("d6_del4_count", bus6.count, 5);
        chk("d6_del4_free", bus6.free_idx, 4);

        bus.rd_en = 1; bus.rd_idx = 1;
        tick();
        chk("inflight_valid", bus.rd_valid, 1);
        rst_n = 0;
        tick();
        idle();
        chk("rstrd_valid", bus.rd_valid, 0);
        chk("rstrd_count", bus.count, 0);
        chk("rstrd_empty", bus.empty, 1);
        chk("rstrd_data", bus.rd_data, 0);
        rst_n = 1;

`ifdef MEMORY_REGISTER_BANK_PARITY_EN
        bus.wr_en = 1; bus.wr_idx = 1; bus.wr_data = 32'h01;
        tick();
        idle();
        bus.rd_en = 1; bus.rd_idx = 1;
        tick();
        idle();
        chk("par_clean", bus.parity_err, 0);
        dut.data_q[1] = 32'h03;
        #1;
        bus.rd_en = 1; bus.rd_idx = 1;
        tick();
        idle();
        chk("par_err_valid", bus.rd_valid, 1);
        chk("par_err", bus.parity_err, 1);
        bus.rd_en = 1; bus.rd_idx = 6;
        tick();
        idle();
        chk("par_miss", bus.parity_err, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
